// File: rtl/fifo_wr_ctrl_if.sv
// rtl/fifo_wr_ctrl_if.sv - write-side bus of the async FIFO write controller
interface fifo_wr_ctrl_if #(
    parameter int ADDR_WIDTH = 4
);
    logic                  wr_en;
    logic                  clr_ovf;
    logic [ADDR_WIDTH:0]   rptr_gray;
    logic                  wclken;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [ADDR_WIDTH:0]   wptr_gray;
    logic                  full;
    logic                  almost_full;
    logic [ADDR_WIDTH:0]   wr_level;
    logic                  wr_ack;
    logic                  overflow;

    modport master (
        output wr_en, clr_ovf, rptr_gray,
        input  wclken, waddr, wptr_gray, full, almost_full, wr_level, wr_ack, overflow
    );

    modport slave (
        input  wr_en, clr_ovf, rptr_gray,
        output wclken, waddr, wptr_gray, full, almost_full, wr_level, wr_ack, overflow
    );
endinterface

// File: rtl/fifo_wr_ctrl.sv
// rtl/fifo_wr_ctrl.sv - write-domain pointer, flag and level control of the async FIFO
module fifo_wr_ctrl #(
    parameter int ADDR_WIDTH  = 4,
    parameter int SYNC_STAGES = 2,
    parameter int AF_MARGIN   = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    fifo_wr_ctrl_if.slave  bus
);
    localparam int PW    = ADDR_WIDTH + 1;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [PW-1:0] AF_LEVEL = PW'(DEPTH - AF_MARGIN);

    logic [PW-1:0] wbin_q, wbin_d;
    logic [PW-1:0] wgray_q, wgray_d;
    logic [PW-1:0] level_q, level_d;
    logic [SYNC_STAGES-1:0][PW-1:0] sync_q, sync_d;
    logic full_q, full_d;
    logic af_q, af_d;
    logic ack_q, ack_d;
    logic ovf_q, ovf_d;
    logic accept;
    logic [PW-1:0] rq_sync, rbin_sync;

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    always_comb begin
        sync_d[0] = bus.rptr_gray;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        rq_sync   = sync_q[SYNC_STAGES-1];
        rbin_sync = gray2bin(rq_sync);

        accept  = bus.wr_en & ~full_q;
        wbin_d  = wbin_q + {{(PW-1){1'b0}}, accept};
        wgray_d = wbin_d ^ (wbin_d >> 1);
        // Full when the next write pointer sits exactly one lap ahead of the synced read pointer.
        full_d  = (wgray_d == {~rq_sync[PW-1:PW-2], rq_sync[PW-3:0]});
        level_d = wbin_d - rbin_sync;
        af_d    = (level_d >= AF_LEVEL);
        ack_d   = accept;

        ovf_d = ovf_q;
        if (bus.wr_en && full_q) begin
            ovf_d = 1'b1;
        end else if (bus.clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbin_q  <= '0;
            wgray_q <= '0;
            level_q <= '0;
            sync_q  <= '0;
            full_q  <= 1'b0;
            af_q    <= 1'b0;
            ack_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            wbin_q  <= wbin_d;
            wgray_q <= wgray_d;
            level_q <= level_d;
            sync_q  <= sync_d;
            full_q  <= full_d;
            af_q    <= af_d;
            ack_q   <= ack_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.wclken      = accept;
    assign bus.waddr       = wbin_q[ADDR_WIDTH-1:0];
    assign bus.wptr_gray   = wgray_q;
    assign bus.full        = full_q;
    assign bus.almost_full = af_q;
    assign bus.wr_level    = level_q;
    assign bus.wr_ack      = ack_q;
    assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// tb/tb_fifo_wr_ctrl.sv - directed self-checking bench for fifo_wr_ctrl
module tb_fifo_wr_ctrl;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    fifo_wr_ctrl_if #(.ADDR_WIDTH(4)) bus ();

    fifo_wr_ctrl #(.ADDR_WIDTH(4), .SYNC_STAGES(2), .AF_MARGIN(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       wr_en;
        logic       clr_ovf;
        logic [4:0] rptr;
        logic       wclken;
        logic [3:0] waddr;
        logic [4:0] wptr;
        logic       full;
        logic       af;
        logic [4:0] level;
        logic       ack;
        logic       ovf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic we, input logic clr, input logic [4:0] rp,
                                input logic wck, input logic [3:0] wa, input logic [4:0] wp,
                                input logic fu, input logic afl, input logic [4:0] lv,
                                input logic ak, input logic ov);
        vec_t v;
        v.wr_en = we; v.clr_ovf = clr; v.rptr = rp; v.wclken = wck; v.waddr = wa;
        v.wptr = wp; v.full = fu; v.af = afl; v.level = lv; v.ack = ak; v.ovf = ov;
        return v;
    endfunction

    function automatic logic [4:0] gray(input int n);
        logic [4:0] b;
        b = 5'(n % 32);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " waddr"},       32'(bus.waddr), 0);
        chk({tag, " wptr_gray"},   32'(bus.wptr_gray), 0);
        chk({tag, " full"},        32'(bus.full), 0);
        chk({tag, " almost_full"}, 32'(bus.almost_full), 0);
        chk({tag, " wr_level"},    32'(bus.wr_level), 0);
        chk({tag, " wr_ack"},      32'(bus.wr_ack), 0);
        chk({tag, " overflow"},    32'(bus.overflow), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] prev_waddr;
        int wraps;
        n_checks = 0;
        n_fail   = 0;

        // fill 16, overflow sequence, drain release (rptr -> gray(4))
        //            we clr rptr    wck addr  wptr     full af level  ack ovf
        vecs.push_back(mk(1, 0, 5'b00000, 1, 4'd0,  5'b00001, 0, 0, 5'd1,  1, 0));
        vecs.push_back(mk(1, 0, 5'b00000, 1, 4'd1,  5'b00011, 0, 0, 5'd2,  1, 0));
        vecs.push_back(mk(1, 0, 5'b00000, 1, 4'd2,  5'b00010, 0, 0, 5'd3,  1, 0));
        vecs.push_back(mk(1, 0, 5'b00000, 1, 4'd3,  5'b00110, 0, 0, 5'd4,  1, 0));
        vecs.push_back(mk(1, 0, 5'b00000, 1, 4'd4,  5'b00111, 0, 0, 5'd5,  1, 0));
        vecs.push_back(mk(1, 0, 5'b00000, 1, 4'd5,  5'b00101, 0, 0, 5'd6,  1, 0));
        vecs.push_back(mk(1, 0, 5'b00000, 1, 4'd6,  5'b00100, 0, 0, 5'd7,  1, 0));
        vecs.push_back(mk(1, 0, 5'b00000, 1, 4'd7,  5'b01100, 0, 0, 5'd8,  1, 0));
        vecs.push_back(mk(1, 0, 5'b00000, 1, 4'd8,  5'b01101, 0, 0, 5'd9,  1, 0));
        vecs.push_back(mk(1, 0, 5'b00000, 1, 4'd9,  5'b01111, 0, 0, 5'd10, 1, 0));
        vecs.push_back(mk(1, 0, 5'b00000, 1, 4'd10, 5'b01110, 0, 0, 5'd11, 1, 0));
        vecs.push_back(mk(1, 0, 5'b00000, 1, 4'd11, 5'b01010, 0, 0, 5'd12, 1, 0));
        vecs.push_back(mk(1, 0, 5'b00000, 1, 4'd12, 5'b01011, 0, 0, 5'd13, 1, 0));
        vecs.push_back(mk(1, 0, 5'b00000, 1, 4'd13, 5'b01001, 0, 1, 5'd14, 1, 0));
        vecs.push_back(mk(1, 0, 5'b00000, 1, 4'd14, 5'b01000, 0, 1, 5'd15, 1, 0));
        vecs.push_back(mk(1, 0, 5'b00000, 1, 4'd15, 5'b11000, 1, 1, 5'd16, 1, 0));
        vecs.push_back(mk(1, 0, 5'b00000, 0, 4'd0,  5'b11000, 1, 1, 5'd16, 0, 1));
        vecs.push_back(mk(1, 0, 5'b00000, 0, 4'd0,  5'b11000, 1, 1, 5'd16, 0, 1));
        vecs.push_back(mk(1, 0, 5'b00000, 0, 4'd0,  5'b11000, 1, 1, 5'd16, 0, 1));
        vecs.push_back(mk(1, 1, 5'b00000, 0, 4'd0,  5'b11000, 1, 1, 5'd16, 0, 1));
        vecs.push_back(mk(0, 1, 5'b00000, 0, 4'd0,  5'b11000, 1, 1, 5'd16, 0, 0));
        vecs.push_back(mk(0, 0, 5'b00110, 0, 4'd0,  5'b11000, 1, 1, 5'd16, 0, 0));
        vecs.push_back(mk(0, 0, 5'b00110, 0, 4'd0,  5'b11000, 1, 1, 5'd16, 0, 0));
        vecs.push_back(mk(0, 0, 5'b00110, 0, 4'd0,  5'b11000, 0, 0, 5'd12, 0, 0));

        rst_n = 1'b0;
        bus.wr_en = 1'b0;
        bus.clr_ovf = 1'b0;
        bus.rptr_gray = '0;
        #1;
        chk_all_zero("por");
        chk("por wclken low", 32'(bus.wclken), 0);
        bus.wr_en = 1'b1;
        #1;
        chk("por wclken follows wr_en", 32'(bus.wclken), 1);
        bus.wr_en = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            bus.wr_en     = vecs[i].wr_en;
            bus.clr_ovf   = vecs[i].clr_ovf;
            bus.rptr_gray = vecs[i].rptr;
            @(negedge clk);
            chk($sformatf("vec%0d wclken", i), 32'(bus.wclken), 32'(vecs[i].wclken));
            chk($sformatf("vec%0d waddr", i),  32'(bus.waddr),  32'(vecs[i].waddr));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d wptr_gray", i),   32'(bus.wptr_gray),   32'(vecs[i].wptr));
            chk($sformatf("vec%0d full", i),        32'(bus.full),        32'(vecs[i].full));
            chk($sformatf("vec%0d almost_full", i), 32'(bus.almost_full), 32'(vecs[i].af));
            chk($sformatf("vec%0d wr_level", i),    32'(bus.wr_level),    32'(vecs[i].level));
            chk($sformatf("vec%0d wr_ack", i),      32'(bus.wr_ack),      32'(vecs[i].ack));
            chk($sformatf("vec%0d overflow", i),    32'(bus.overflow),    32'(vecs[i].ovf));
        end

        // asynchronous reset mid-cycle with live state
        bus.clr_ovf = 1'b0;
        #2;
        bus.wr_en = 1'b1;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        chk("midrst wclken follows wr_en", 32'(bus.wclken), 1);
        bus.wr_en = 1'b0;
        bus.rptr_gray = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;

        // wrap: 40 writes with the read pointer trailing by 3
        wraps = 0;
        prev_waddr = bus.waddr;
        for (int k = 0; k < 40; k++) begin
            bus.rptr_gray = gray(k >= 3 ? k - 3 : 0);
            bus.wr_en = 1'b1;
            @(negedge clk);
            if (k > 0 && prev_waddr == 4'd15 && bus.waddr == 4'd0) wraps++;
            prev_waddr = bus.waddr;
            chk($sformatf("wrap%0d waddr", k),  32'(bus.waddr), 32'(k % 16));
            chk($sformatf("wrap%0d wclken", k), 32'(bus.wclken), 1);
            @(posedge clk);
            #1;
            chk($sformatf("wrap%0d one-bit", k),
                32'($countones(bus.wptr_gray ^ gray(k))), 1);
            chk($sformatf("wrap%0d full", k), 32'(bus.full), 0);
        end
        bus.wr_en = 1'b0;
        chk("wrap waddr wraps", 32'(wraps), 2);
        chk("wrap final wptr_gray", 32'(bus.wptr_gray), 32'(5'b01100));

        // simultaneous write and read-pointer advance at level 15
        rst_n = 1'b0;
        bus.rptr_gray = '0;
        #1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        bus.wr_en = 1'b1;
        repeat (15) @(posedge clk);
        #1 bus.wr_en = 1'b0;
        chk("sim pre level", 32'(bus.wr_level), 15);
        chk("sim pre full", 32'(bus.full), 0);
        chk("sim pre almost_full", 32'(bus.almost_full), 1);
        bus.rptr_gray = 5'b00001;
        repeat (2) @(posedge clk);
        #1 bus.wr_en = 1'b1;
        @(negedge clk);
        chk("sim wclken", 32'(bus.wclken), 1);
        chk("sim waddr", 32'(bus.waddr), 15);
        @(posedge clk);
        #1 bus.wr_en = 1'b0;
        chk("sim full", 32'(bus.full), 0);
        chk("sim wr_level", 32'(bus.wr_level), 15);
        chk("sim wr_ack", 32'(bus.wr_ack), 1);
        chk("sim wptr_gray", 32'(bus.wptr_gray), 32'(5'b11000));
        @(posedge clk);
        #1;
        chk("sim post level", 32'(bus.wr_level), 15);
        chk("sim post full", 32'(bus.full), 0);
        chk("sim post waddr", 32'(bus.waddr), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fifo_wr_ctrl.md
Name: fifo_wr_ctrl

Overview:
Write-domain control stage of the asynchronous FIFO. It feeds the flip-flop synchronizer chain that carries the write pointer into the read domain, and it consumes the read pointer synchronized back into this domain. It produces the memory write address and enable, the Gray-coded write pointer, full and almost-full flags, a conservative fill level, and a sticky overflow flag. It runs on a single clock.

Parameters:
ADDR_WIDTH, 4, memory address width; DEPTH = 2**ADDR_WIDTH.
SYNC_STAGES, 2, number of flops in the internal synchronizer for the read pointer; minimum 2.
AF_MARGIN, 2, almost_full asserts when level >= DEPTH - AF_MARGIN.

Ports:
clk  in  1  write-domain clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
wr_en  in  1  write request for the current cycle.
clr_ovf  in  1  synchronous clear of the sticky overflow flag.
rptr_gray  in  ADDR_WIDTH+1  Gray-coded read pointer from the read domain; asynchronous to clk.
wclken  out  1  memory write enable; combinational, equals wr_en & ~full.
waddr  out  ADDR_WIDTH  memory write address; the low bits of the binary write pointer.
wptr_gray  out  ADDR_WIDTH+1  registered Gray-coded write pointer, sent to the read-domain synchronizer.
full  out  1  registered full flag.
almost_full  out  1  registered almost-full flag.
wr_level  out  ADDR_WIDTH+1  registered conservative occupancy, 0..DEPTH.
wr_ack  out  1  registered; high one cycle after an accepted write.
overflow  out  1  sticky flag; set by a write attempted while full.

Behaviour:
- Reset (asynchronous, rst_n=0): every register clears to 0. This covers wbin, wptr_gray, all synchronizer stages, full, almost_full, wr_level, wr_ack and overflow. Consequently waddr=0 and wclken=wr_en. Reset applied mid-operation discards all state immediately, without waiting for a clock edge.
- Synchronizer: rptr_gray passes through SYNC_STAGES flops to give rq_sync. Nothing else samples rptr_gray.
- Pointer update:
  - accept = wr_en & ~full.
  - wbin_next = wbin + accept, wrapping modulo 2**(ADDR_WIDTH+1).
  - wgray_next = wbin_next ^ (wbin_next >> 1).
  - wbin and wptr_gray load their next values every cycle. wptr_gray is therefore glitch-free: exactly one bit changes per accepted write.
- Full:
  - full <= (wgray_next == {~rq_sync[MSB:MSB-1], rq_sync[MSB-2:0]}).
  - full therefore asserts on the edge that accepts the DEPTH-th outstanding write, with no bubble.
  - full deasserts SYNC_STAGES+1 edges after rptr_gray advances (pessimistic).
- Level:
  - rbin_sync is the Gray-to-binary conversion of rq_sync.
  - level_next = (wbin_next - rbin_sync), taken modulo 2**(ADDR_WIDTH+1).
  - wr_level <= level_next.
  - almost_full <= (level_next >= DEPTH - AF_MARGIN).
- wr_ack <= accept.
- Overflow:
  - overflow <= 1 when wr_en & full. Otherwise it clears when clr_ovf=1, and otherwise holds.
  - If set and clear occur in the same cycle, set wins.
  - A rejected write leaves wbin, wptr_gray and waddr unchanged and does not pulse wclken.
- Wrap-around: the pointer MSB toggles each DEPTH writes. Full and level stay correct across any number of wraps.
- Simultaneous events: a write accepted in the same cycle that rq_sync advances uses both new values in full and level_next. No write is lost and no false full is produced.

Test Plan:
- Reset check: assert rst_n=0 mid-clock with wr_en=1 -> all outputs 0 immediately; wclken follows wr_en.
- Fill: hold rptr_gray=0 and issue 16 back-to-back writes (ADDR_WIDTH=4) -> waddr runs 0..15. full=1 after the 16th accepting edge, with wptr_gray=5'b11000 and wr_level=16. almost_full=1 from the edge where level reaches 14. wr_ack high for 16 cycles.
- Overflow: while full, wr_en=1 for 3 cycles -> wclken=0, pointers frozen, overflow=1. Then clr_ovf=1 together with wr_en=1 -> overflow stays 1. Then clr_ovf=1 with wr_en=0 -> overflow=0.
- Drain release: full FIFO, change rptr_gray to gray(4)=5'b00110 -> full=0 and wr_level=12 exactly 3 edges later (SYNC_STAGES=2). almost_full drops on that same edge.
- Wrap: make 40 writes with rptr_gray tracking (read pointer kept 3 behind) -> never full. waddr wraps 15->0 twice. wptr_gray changes exactly one bit per write and reaches gray(40 mod 32)=5'b01100.
- Simultaneous: at level 15, one edge carries both a write and a read-pointer advance of 1 arriving through the synchronizer -> full stays 0, wr_level stays 15, and no write is dropped.
